// File: rtl/stack_transfer_sequencer.sv
// Sequences PUSH/POP and STM/LDM multi-register transfers between the register file and memory,
// then writes the adjusted stack pointer back.
module stack_transfer_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_load,
  input  logic [8:0]  reg_list,
  input  logic [31:0] base_in,
  output logic [3:0]  read_select,
  input  logic [31:0] read_data,
  output logic [3:0]  write_dest,
  output logic        write_en,
  output logic [31:0] write_in,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] WB   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  localparam logic [3:0] SP_CODE = 4'd8;
  localparam logic [3:0] PC_CODE = 4'd9;
  localparam logic [3:0] LR_CODE = 4'd10;

  logic [1:0]  state_q;
  logic        is_load_q;
  logic [8:0]  list_q;
  logic [31:0] base_q;
  logic [31:0] addr_q;
  logic [3:0]  n_q;

  logic [3:0]  start_n;
  logic [31:0] start_four_n;
  logic [31:0] four_n;
  logic [31:0] sp_new;
  logic [8:0]  low_bit;
  logic [8:0]  list_rest;
  logic [3:0]  active_code;
  logic        accept;

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) begin
      c = c + {3'd0, v[i]};
    end
    return c;
  endfunction

  assign start_n      = popcount9(reg_list);
  assign start_four_n = {26'd0, start_n, 2'b00};
  assign four_n       = {26'd0, n_q, 2'b00};
  assign sp_new       = is_load_q ? (base_q + four_n) : (base_q - four_n);

  // Two's-complement trick isolates the lowest set bit of the remaining list.
  assign low_bit   = list_q & (~list_q + 9'd1);
  assign list_rest = list_q & ~low_bit;
  assign accept    = (state_q == XFER) && mem_ready;

  // Bit 8 names LR on a store and PC on a load.
  always_comb begin
    active_code = 4'd0;
    for (int i = 8; i >= 0; i--) begin
      if (list_q[i]) begin
        if (i == 8) begin
          active_code = is_load_q ? PC_CODE : LR_CODE;
        end else begin
          active_code = 4'(i);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      is_load_q <= 1'b0;
      list_q    <= 9'd0;
      base_q    <= 32'd0;
      addr_q    <= 32'd0;
      n_q       <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            is_load_q <= is_load;
            list_q    <= reg_list;
            base_q    <= base_in;
            n_q       <= start_n;
            addr_q    <= is_load ? base_in : (base_in - start_four_n);
            state_q   <= (start_n == 4'd0) ? DONE : XFER;
          end
        end
        XFER: begin
          if (mem_ready) begin
            list_q <= list_rest;
            addr_q <= addr_q + 32'd4;
            if (list_rest == 9'd0) begin
              state_q <= WB;
            end
          end
        end
        WB:      state_q <= DONE;
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    read_select = 4'd0;
    write_dest  = 4'd0;
    write_en    = 1'b0;
    write_in    = 32'd0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = 32'd0;
    mem_wdata   = 32'd0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state_q)
      XFER: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = !is_load_q;
        mem_addr = addr_q;
        if (!is_load_q) begin
          read_select = active_code;
          mem_wdata   = read_data;
        end else if (accept) begin
          write_en   = 1'b1;
          write_dest = active_code;
          write_in   = mem_rdata;
        end
      end
      WB: begin
        busy       = 1'b1;
        write_en   = 1'b1;
        write_dest = SP_CODE;
        write_in   = sp_new;
      end
      DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/stack_transfer_sequencer.md
STACK_TRANSFER_SEQUENCER -- requirements
Module: stack_transfer_sequencer

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clk  in  1  system clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  request a multi-register transfer; sampled only in IDLE.
REQ-005 is_load  in  1  1 = POP/LDM (memory to registers), 0 = PUSH/STM (registers to memory).
REQ-006 reg_list  in  9  bits 0-7 = R0-R7; bit 8 = LR on store, PC on load.
REQ-007 base_in  in  32  current SP value, latched with start.
REQ-008 read_select  out  4  register-file read port select (R0-R7 = 0-7, SP = 8, PC = 9, LR = 10).
REQ-009 read_data  in  32  register-file read port data, combinational from read_select.
REQ-010 write_dest  out  4  register-file write destination, same encoding.
REQ-011 write_en  out  1  register-file write strobe.
REQ-012 write_in  out  32  register-file write data.
REQ-013 mem_req / mem_we  out  1 / 1  memory request valid / write enable.
REQ-014 mem_addr / mem_wdata  out  32 / 32  memory address / write data.
REQ-015 mem_ready / mem_rdata  in  1 / 32  memory accept strobe / read data, valid in the mem_ready cycle.
REQ-016 busy / done  out  1 / 1  transfer in progress / one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, XFER, WB and DONE.
REQ-018 In IDLE with start=1 it SHALL latch is_load, reg_list and base_in, and compute n = popcount(reg_list).
REQ-019 With n=0 it SHALL go IDLE->DONE, issuing no mem_req and no write_en.
REQ-020 With n>0 it SHALL go IDLE->XFER.
REQ-021 Start address SHALL be base-4n for store and base for load; all address arithmetic wraps modulo 2^32 and base bits [1:0] pass unmodified.
REQ-022 In XFER the active register SHALL be the lowest set bit of the remaining list.
REQ-023 In XFER the outputs SHALL be: mem_req=1, mem_we=!is_load, mem_addr=current address.
REQ-024 On store, XFER SHALL drive read_select to the active register code and mem_wdata=read_data.
REQ-025 All XFER outputs SHALL hold stable while mem_ready=0.
REQ-026 mem_ready SHALL be ignored whenever mem_req=0.
REQ-027 On a cycle with mem_req=1 and mem_ready=1, it SHALL clear the active bit and add 4 to the address.
REQ-028 On load, in that same cycle it SHALL drive write_en=1, write_dest=active code and write_in=mem_rdata.
REQ-029 When the last bit is consumed it SHALL go XFER->WB.
REQ-030 WB SHALL last one cycle with write_en=1, write_dest=8 (SP) and write_in = base-4n for store or base+4n for load, then go to DONE.
REQ-031 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-032 busy SHALL be 1 in XFER and WB and 0 in IDLE and DONE.
REQ-033 start SHALL be ignored outside IDLE, including in the DONE cycle.
REQ-034 With mem_ready held high, done SHALL assert exactly n+2 cycles after the start-sampling edge.
REQ-035 Memory order SHALL be ascending by register number: lowest register at lowest address.
REQ-036 write_en SHALL never assert outside XFER-load-accept and WB cycles.
REQ-037 When idle, read_select, write_dest and mem_addr SHALL be 0.

Reset
REQ-038 Reset SHALL force IDLE, with busy, done, mem_req, mem_we and write_en all 0, and all address/data outputs 0.
REQ-039 Reset asserted mid-transfer SHALL take effect at that edge: no further memory requests, no SP writeback, and no done pulse.
REQ-040 Reset SHALL have priority over start when both are high in the same cycle.

Verification
REQ-041 Store, reg_list=0x105, base 0x100, ready=1: writes R0@0xF4, R2@0xF8, LR(read_select 10)@0xFC, then SP=0xF4; done on the 5th cycle after start.
REQ-042 Load, reg_list=0x102, base 0x200, rdata 0xA then 0xB: R1=0xA from 0x200, PC(9)=0xB from 0x204, then SP=0x208.
REQ-043 reg_list=0 -> done the cycle after start; mem_req and write_en never assert.
REQ-044 Store of R3 with mem_ready low for 3 cycles: mem_addr, mem_wdata and read_select are held constant; accepted on the 4th cycle.
REQ-045 Reset mid-load after the first accept: only that one register write occurs, with no SP write and no done; a start pulsed while busy is ignored.
REQ-046 Store of 3 registers with base 0x4: start address 0xFFFFFFF8 and SP writeback 0xFFFFFFF8.
